// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-size bounds, parity encoding and TX state type.
// Imported by the TX front-end and the baud accumulator.
package uart_pkg;
  localparam int unsigned MIN_FRAME_SIZE = 8;
  localparam int unsigned MAX_FRAME_SIZE = 11;
  localparam logic [1:0]  PARITY_NONE    = 2'b00;
  localparam int unsigned PARITY_ODD_BIT = 0;
  localparam int unsigned ACC_W          = 16;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned SHIFT_W        = MAX_FRAME_SIZE + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;
endpackage

// File: rtl/baud_acc.sv
// Fractional baud accumulator: bit ACC_W of the register flags the end of a bit
// period; the carry is dropped on the next add so the phase wraps at 2^ACC_W.
module baud_acc
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] incr_i,
  output logic             ovf_o
);

  logic [ACC_W:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= {1'b0, acc_q[ACC_W-1:0]} + {1'b0, incr_i};
    end
  end

  assign ovf_o = acc_q[ACC_W];

endmodule

// File: rtl/tx_frontend.sv
// UART transmit front-end: accepts one character per valid/ready handshake and
// shifts start, data (LSB first), optional parity and stop bits onto uart_tx_o.
module tx_frontend
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cr_acc_incr_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  tx_state_t          state_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   incr_q;
  logic               tx_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;
  logic               baud_ovf;
  logic               period_end;

  function automatic logic [CNT_W-1:0] frame_size(input logic ds, input logic [1:0] p,
                                                  input logic s);
    frame_size = CNT_W'(MIN_FRAME_SIZE) + CNT_W'(ds) + CNT_W'(p != PARITY_NONE) + CNT_W'(s);
  endfunction

  // Bits above the parity slot stay 1, so stop bits come for free and the
  // shift fill keeps the line high for any trailing period.
  function automatic logic [SHIFT_W-1:0] build_frame(input logic [7:0] d, input logic ds,
                                                     input logic [1:0] p);
    logic [SHIFT_W-1:0] f;
    logic               par;
    f    = '1;
    f[0] = 1'b0;
    par  = p[PARITY_ODD_BIT] ^ (ds ? ^d : ^d[6:0]);
    if (ds) begin
      f[8:1] = d;
      if (p != PARITY_NONE) f[9] = par;
    end else begin
      f[7:1] = d[6:0];
      if (p != PARITY_NONE) f[8] = par;
    end
    build_frame = f;
  endfunction

  assign accept     = (state_q == IDLE) && valid_i && ready_q;
  assign period_end = (state_q == SEND) && baud_ovf;

  baud_acc u_baud_acc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept),
    .en_i   (state_q == SEND),
    .incr_i (incr_q),
    .ovf_o  (baud_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      incr_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            state_q <= SEND;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            shift_q <= build_frame(data_i, cr_ds_i, cr_p_i);
            cnt_q   <= frame_size(cr_ds_i, cr_p_i, cr_s_i) + CNT_W'(1);
            incr_q  <= cr_acc_incr_i;
          end
        end
        SEND: begin
          if (period_end) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            shift_q <= {1'b1, shift_q[SHIFT_W-1:1]};
            if (cnt_q == CNT_W'(1)) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            tx_q <= shift_q[0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign uart_tx_o = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
